// File: rtl/stack_ptr_unit.sv
// Stack-pointer unit: INC/DEC/ADD_REL in one cycle, multi-beat little-endian LOAD
// from the byte bus sequenced by a two-state FSM with a valid/ready handshake.
module stack_ptr_unit #(
    parameter int          WIDTH       = 16,
    parameter logic [63:0] RESET_VALUE = 64'hFFFE
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op,
    output logic             op_ready,
    input  logic [7:0]       data_in,
    input  logic             byte_valid,
    input  logic             abort,
    output logic [WIDTH-1:0] sp,
    output logic             flag_h,
    output logic             flag_c,
    output logic             wrap,
    output logic             busy
);

    localparam int                BYTES  = WIDTH / 8;
    localparam int                CNT_W  = $clog2(BYTES);
    localparam logic [CNT_W-1:0]  LAST   = CNT_W'(BYTES - 1);
    localparam logic [WIDTH-1:0]  RST_SP = WIDTH'(RESET_VALUE);

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_INC     = 3'd1;
    localparam logic [2:0] OP_DEC     = 3'd2;
    localparam logic [2:0] OP_LOAD    = 3'd3;
    localparam logic [2:0] OP_ADD_REL = 3'd4;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-9:0]   stage_q, stage_d;
    logic [WIDTH-1:0]   sp_q, sp_d;
    logic               flag_h_q, flag_h_d;
    logic               flag_c_q, flag_c_d;
    logic               wrap_q, wrap_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            stage_q  <= '0;
            sp_q     <= RST_SP;
            flag_h_q <= 1'b0;
            flag_c_q <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stage_q  <= stage_d;
            sp_q     <= sp_d;
            flag_h_q <= flag_h_d;
            flag_c_q <= flag_c_d;
            wrap_q   <= wrap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stage_d  = stage_q;
        sp_d     = sp_q;
        flag_h_d = flag_h_q;
        flag_c_d = flag_c_q;
        wrap_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (op_valid) begin
                    case (op)
                        OP_INC: begin
                            sp_d   = sp_q + WIDTH'(1);
                            wrap_d = &sp_q;
                        end
                        OP_DEC: begin
                            sp_d   = sp_q - WIDTH'(1);
                            wrap_d = ~|sp_q;
                        end
                        OP_LOAD: begin
                            stage_d[7:0] = data_in;
                            cnt_d        = CNT_W'(1);
                            state_d      = LOAD_BUSY;
                        end
                        OP_ADD_REL: begin
                            sp_d     = sp_q + {{(WIDTH-8){data_in[7]}}, data_in};
                            // Flags always come from the unsigned low-byte sum.
                            flag_h_d = (5'(sp_q[3:0]) + 5'(data_in[3:0])) > 5'd15;
                            flag_c_d = (9'(sp_q[7:0]) + 9'(data_in)) > 9'd255;
                        end
                        default: ; // NOP and reserved opcodes
                    endcase
                end
            end
            LOAD_BUSY: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (byte_valid) begin
                    if (cnt_q == LAST) begin
                        // Whole pointer is written at once on the final beat.
                        sp_d    = {data_in, stage_q};
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        for (int i = 1; i < BYTES - 1; i++) begin
                            if (cnt_q == CNT_W'(i)) stage_d[i*8 +: 8] = data_in;
                        end
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign op_ready = (state_q == IDLE);
    assign busy     = (state_q == LOAD_BUSY);
    assign sp       = sp_q;
    assign flag_h   = flag_h_q;
    assign flag_c   = flag_c_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_stack_ptr_unit.sv
// Directed bench for stack_ptr_unit: a 16-bit and a 24-bit instance driven in turn.
module tb_stack_ptr_unit;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // 16-bit instance
    logic        reset_a, op_valid_a, byte_valid_a, abort_a;
    logic [2:0]  op_a;
    logic [7:0]  data_a;
    logic        op_ready_a, flag_h_a, flag_c_a, wrap_a, busy_a;
    logic [15:0] sp_a;

    // 24-bit instance
    logic        reset_b, op_valid_b, byte_valid_b, abort_b;
    logic [2:0]  op_b;
    logic [7:0]  data_b;
    logic        op_ready_b, flag_h_b, flag_c_b, wrap_b, busy_b;
    logic [23:0] sp_b;

    stack_ptr_unit #(.WIDTH(16), .RESET_VALUE(64'hFFFE)) dut16 (
        .clock(clock), .reset(reset_a), .op_valid(op_valid_a), .op(op_a),
        .op_ready(op_ready_a), .data_in(data_a), .byte_valid(byte_valid_a),
        .abort(abort_a), .sp(sp_a), .flag_h(flag_h_a), .flag_c(flag_c_a),
        .wrap(wrap_a), .busy(busy_a)
    );

    stack_ptr_unit #(.WIDTH(24), .RESET_VALUE(64'hFFFFFE)) dut24 (
        .clock(clock), .reset(reset_b), .op_valid(op_valid_b), .op(op_b),
        .op_ready(op_ready_b), .data_in(data_b), .byte_valid(byte_valid_b),
        .abort(abort_b), .sp(sp_b), .flag_h(flag_h_b), .flag_c(flag_c_b),
        .wrap(wrap_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_a();
        op_valid_a = 0; op_a = 3'd0; byte_valid_a = 0; abort_a = 0; data_a = 8'h00;
    endtask

    task automatic idle_b();
        op_valid_b = 0; op_b = 3'd0; byte_valid_b = 0; abort_b = 0; data_b = 8'h00;
    endtask

    task automatic op16(input logic [2:0] o, input logic [7:0] d);
        idle_a(); op_valid_a = 1; op_a = o; data_a = d; tick(); idle_a();
    endtask

    task automatic beat16(input logic [7:0] d);
        idle_a(); byte_valid_a = 1; data_a = d; tick(); idle_a();
    endtask

    task automatic op24(input logic [2:0] o, input logic [7:0] d);
        idle_b(); op_valid_b = 1; op_b = o; data_b = d; tick(); idle_b();
    endtask

    task automatic beat24(input logic [7:0] d);
        idle_b(); byte_valid_b = 1; data_b = d; tick(); idle_b();
    endtask

    initial begin
        idle_a(); idle_b();
        // Reset with an INC presented: reset must win.
        reset_a = 1; reset_b = 1; op_valid_a = 1; op_a = 3'd1;
        tick(); tick();
        check("rst_sp", sp_a, 32'hFFFE);
        check("rst_flags", {flag_h_a, flag_c_a}, 0);
        check("rst_wrap", wrap_a, 0);
        check("rst_ready", op_ready_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_sp24", sp_b, 32'hFFFFFE);
        reset_a = 0; reset_b = 0; idle_a();

        // INC / DEC with wrap pulses
        op16(3'd1, 8'h00);
        check("inc1_sp", sp_a, 32'hFFFF);
        check("inc1_wrap", wrap_a, 0);
        op16(3'd1, 8'h00);
        check("inc2_sp", sp_a, 32'h0000);
        check("inc2_wrap", wrap_a, 1);
        op16(3'd2, 8'h00);
        check("dec_sp", sp_a, 32'hFFFF);
        check("dec_wrap", wrap_a, 1);
        tick();
        check("wrap_pulse_end", wrap_a, 0);

        // ADD_REL with both carries, then INC keeps flags
        op16(3'd3, 8'hF8); beat16(8'h00);
        check("ld_f8", sp_a, 32'h00F8);
        op16(3'd4, 8'h0B);
        check("addp_sp", sp_a, 32'h0103);
        check("addp_h", flag_h_a, 1);
        check("addp_c", flag_c_a, 1);
        op16(3'd1, 8'h00);
        check("inc_keep_sp", sp_a, 32'h0104);
        check("inc_keep_flags", {flag_h_a, flag_c_a}, 2'b11);
        op16(3'd3, 8'h05); beat16(8'h00);
        check("ld_keep_flags", {flag_h_a, flag_c_a}, 2'b11);
        op16(3'd4, 8'h80);
        check("addn_sp", sp_a, 32'hFF85);
        check("addn_flags", {flag_h_a, flag_c_a}, 2'b00);
        check("addn_wrap", wrap_a, 0);

        // LOAD with two stall cycles and ignored op_valid pulses
        op16(3'd3, 8'h34);
        check("ld_busy0", busy_a, 1);
        check("ld_ready0", op_ready_a, 0);
        check("ld_hold0", sp_a, 32'hFF85);
        op_valid_a = 1; op_a = 3'd1; tick();
        check("ld_ready1", op_ready_a, 0);
        check("ld_hold1", sp_a, 32'hFF85);
        op_valid_a = 1; op_a = 3'd4; data_a = 8'h7F; tick(); idle_a();
        check("ld_ready2", op_ready_a, 0);
        check("ld_hold2", sp_a, 32'hFF85);
        beat16(8'h12);
        check("ld_sp", sp_a, 32'h1234);
        check("ld_ready_end", op_ready_a, 1);
        check("ld_flags_kept", {flag_h_a, flag_c_a}, 2'b00);

        // Abort beats byte_valid
        op16(3'd3, 8'h34);
        idle_a(); abort_a = 1; byte_valid_a = 1; data_a = 8'h99; tick(); idle_a();
        check("abort_sp", sp_a, 32'h1234);
        check("abort_busy", busy_a, 0);
        check("abort_ready", op_ready_a, 1);
        op16(3'd3, 8'hCD); beat16(8'hAB);
        check("ld_after_abort", sp_a, 32'hABCD);

        // Abort and byte_valid ignored while idle
        idle_a(); abort_a = 1; byte_valid_a = 1; data_a = 8'h55; tick(); idle_a();
        check("idle_ignore_sp", sp_a, 32'hABCD);
        check("idle_ignore_busy", busy_a, 0);

        // Reset mid-load
        op16(3'd3, 8'h34);
        reset_a = 1; tick(); reset_a = 0;
        check("rstld_sp", sp_a, 32'hFFFE);
        check("rstld_busy", busy_a, 0);
        beat16(8'h12);
        check("late_beat_sp", sp_a, 32'hFFFE);
        check("late_beat_busy", busy_a, 0);

        // 24-bit instance
        op24(3'd3, 8'h56);
        check("w24_busy", busy_b, 1);
        beat24(8'h34);
        check("w24_mid_hold", sp_b, 32'hFFFFFE);
        check("w24_mid_busy", busy_b, 1);
        beat24(8'h12);
        check("w24_ld", sp_b, 32'h123456);
        check("w24_ready", op_ready_b, 1);
        op24(3'd3, 8'hFF); beat24(8'hFF); beat24(8'hFF);
        check("w24_ld_ff", sp_b, 32'hFFFFFF);
        op24(3'd1, 8'h00);
        check("w24_inc_sp", sp_b, 32'h000000);
        check("w24_inc_wrap", wrap_b, 1);
        op24(3'd4, 8'hFF);
        check("w24_add_sp", sp_b, 32'hFFFFFF);
        check("w24_add_flags", {flag_h_b, flag_c_b}, 2'b00);
        check("w24_add_wrap", wrap_b, 0);
        op24(3'd6, 8'h42);
        check("w24_rsv_sp", sp_b, 32'hFFFFFF);
        check("w24_rsv_ready", op_ready_b, 1);
        check("w24_rsv_busy", busy_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
